// File: rtl/bram_wrap_banked.sv
// bram_wrap_banked: banked BRAM front-end with single-cycle grant and fixed-latency in-order responses
module bram_wrap_banked #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int N_BANKS    = 4,
    parameter int INTERLEAVE = 1,
    parameter int RD_LATENCY = 1,
    localparam int BE_WIDTH  = DATA_WIDTH / 8,
    localparam int BW        = $clog2(N_BANKS),
    localparam int BA        = ADDR_WIDTH - BW
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           data_req_i,
    input  logic [ADDR_WIDTH-1:0]          data_add_i,
    input  logic                           data_wen_i,
    input  logic [DATA_WIDTH-1:0]          data_wdata_i,
    input  logic [BE_WIDTH-1:0]            data_be_i,
    output logic                           data_gnt_o,
    output logic                           data_r_valid_o,
    output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
    output logic [N_BANKS*BA-1:0]          ADDRA_o,
    output logic [N_BANKS*DATA_WIDTH-1:0]  DINA_o,
    input  logic [N_BANKS*DATA_WIDTH-1:0]  DOUTA_i,
    output logic [N_BANKS-1:0]             ENA_o,
    output logic [N_BANKS*BE_WIDTH-1:0]    WEA_o
);
    // A single bank still needs a one-bit tag so the pipeline has something to carry
    localparam int BWS = (BW > 0) ? BW : 1;

    logic                  gnt;
    logic [BWS-1:0]        bank;
    logic [BA-1:0]         baddr;
    logic [RD_LATENCY-1:0] vld_q, ld_q;
    logic [BWS-1:0]        bank_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

    assign gnt        = data_req_i & ~reset;
    assign data_gnt_o = gnt;
    assign bank  = (BW == 0) ? '0 : (INTERLEAVE != 0) ? BWS'(data_add_i) : BWS'(data_add_i >> BA);
    assign baddr = (INTERLEAVE != 0) ? BA'(data_add_i >> BW) : BA'(data_add_i);

    for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
        assign ENA_o[g]                              = gnt && (bank == BWS'(g));
        assign WEA_o[g*BE_WIDTH +: BE_WIDTH]         = (ENA_o[g] && !data_wen_i) ? data_be_i : '0;
        assign ADDRA_o[g*BA +: BA]                   = baddr;
        assign DINA_o[g*DATA_WIDTH +: DATA_WIDTH]    = data_wdata_i;
    end

    // Shift {valid, is_load, bank} tags so each response lines up with its bank's read data
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            ld_q  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) bank_q[i] <= '0;
        end else begin
            vld_q[0]  <= gnt;
            ld_q[0]   <= data_wen_i;
            bank_q[0] <= bank;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                ld_q[i]   <= ld_q[i-1];
                bank_q[i] <= bank_q[i-1];
            end
        end
    end

    // Load responses take the tagged bank's output, store responses return zero, idle cycles hold
    always_comb begin
        rdata_d = !vld_q[RD_LATENCY-1] ? rdata_q :
                  ld_q[RD_LATENCY-1]   ? DOUTA_i[bank_q[RD_LATENCY-1]*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    // Remember the last response so the data output holds between responses
    always_ff @(posedge clk) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign data_r_valid_o = vld_q[RD_LATENCY-1] & ~reset;
    assign data_r_rdata_o = reset ? '0 : rdata_d;
endmodule

// File: tb/tb_bram_wrap_banked.sv
// tb_bram_wrap_banked: directed checks of banking, byte writes, latency and reset on three configurations
module tb_bram_wrap_banked;
    logic         clk = 0, init = 1, rst_a = 1, rst_b = 1, rst_c = 1;
    logic         req = 0, wen = 0;
    logic [9:0]   add = 0;
    logic [31:0]  wdata = 0;
    logic [3:0]   be = 0;
    int           checks = 0, errors = 0;
    logic [31:0]  want;

    logic         gnt_a, rv_a, gnt_b, rv_b, gnt_c, rv_c;
    logic [31:0]  rdata_a, rdata_b, rdata_c, addra_a, addra_b, addra_c;
    logic [127:0] dina_a, dina_b, dina_c, douta_a, douta_b, douta_c, db0, db1;
    logic [3:0]   ena_a, ena_b, ena_c;
    logic [15:0]  wea_a, wea_b, wea_c;
    logic [31:0]  mem_a [4][256];
    logic [31:0]  mem_b [4][256];
    logic [31:0]  t_a, t_b;

    always #5 clk = ~clk;
    assign douta_c = {4{32'hDEADBEEF}};

    bram_wrap_banked u_a (
        .clk(clk), .reset(rst_a), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt_a), .data_r_valid_o(rv_a),
        .data_r_rdata_o(rdata_a), .ADDRA_o(addra_a), .DINA_o(dina_a), .DOUTA_i(douta_a),
        .ENA_o(ena_a), .WEA_o(wea_a));

    bram_wrap_banked #(.INTERLEAVE(0), .RD_LATENCY(3)) u_b (
        .clk(clk), .reset(rst_b), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt_b), .data_r_valid_o(rv_b),
        .data_r_rdata_o(rdata_b), .ADDRA_o(addra_b), .DINA_o(dina_b), .DOUTA_i(douta_b),
        .ENA_o(ena_b), .WEA_o(wea_b));

    bram_wrap_banked #(.RD_LATENCY(4)) u_c (
        .clk(clk), .reset(rst_c), .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt_c), .data_r_valid_o(rv_c),
        .data_r_rdata_o(rdata_c), .ADDRA_o(addra_c), .DINA_o(dina_c), .DOUTA_i(douta_c),
        .ENA_o(ena_c), .WEA_o(wea_c));

    // Write-first BRAM, one-cycle read, content preset to C0DE0000 | word address
    always @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < 4; k++) for (int j = 0; j < 256; j++) mem_a[k][j] <= 32'hC0DE0000 | 32'(j*4+k);
        end else begin
            for (int k = 0; k < 4; k++) if (ena_a[k]) begin
                t_a = mem_a[k][addra_a[k*8 +: 8]];
                for (int b = 0; b < 4; b++) if (wea_a[k*4+b]) t_a[b*8 +: 8] = dina_a[k*32+b*8 +: 8];
                mem_a[k][addra_a[k*8 +: 8]] <= t_a;
                douta_a[k*32 +: 32] <= t_a;
            end
        end
    end

    // Write-first BRAM, three-cycle read, content preset to B0000000 | word address (high-bit banking)
    always @(posedge clk) begin
        if (init) begin
            for (int k = 0; k < 4; k++) for (int j = 0; j < 256; j++) mem_b[k][j] <= 32'hB0000000 | 32'(k*256+j);
        end else begin
            for (int k = 0; k < 4; k++) if (ena_b[k]) begin
                t_b = mem_b[k][addra_b[k*8 +: 8]];
                for (int b = 0; b < 4; b++) if (wea_b[k*4+b]) t_b[b*8 +: 8] = dina_b[k*32+b*8 +: 8];
                mem_b[k][addra_b[k*8 +: 8]] <= t_b;
                db0[k*32 +: 32] <= t_b;
            end
        end
        db1     <= db0;
        douta_b <= db1;
    end

    task automatic drive(input logic r, input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] e);
        @(negedge clk);
        req = r; wen = w; add = a; wdata = d; be = e;
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 10'd3, 32'hFFFFFFFF, 4'hF);
        checks++; if (gnt_a !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %h want 0", gnt_a); end
        checks++; if (ena_a !== 4'h0) begin errors++; $display("FAIL rst_ena: got %h want 0", ena_a); end
        checks++; if (wea_a !== 16'h0) begin errors++; $display("FAIL rst_wea: got %h want 0", wea_a); end
        checks++; if (rv_a !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %h want 0", rv_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata_a); end
        @(negedge clk);
        init = 0; rst_a = 0; req = 1; wen = 1; add = 10'd0; be = 4'h0;
        #1;
        checks++; if (gnt_a !== 1'b1) begin errors++; $display("FAIL first_gnt: got %h want 1", gnt_a); end
        checks++; if (ena_a !== 4'b0001) begin errors++; $display("FAIL first_ena: got %h want 1", ena_a); end
        drive(0, 0, 10'd0, 32'h0, 4'h0);
        checks++; if (rv_a !== 1'b1) begin errors++; $display("FAIL first_rvalid: got %h want 1", rv_a); end
        checks++; if (rdata_a !== 32'hC0DE0000) begin errors++; $display("FAIL first_rdata: got %h want c0de0000", rdata_a); end
    endtask

    task automatic test_store_load();
        for (int c = 0; c < 37; c++) begin
            if (c < 16)      drive(1, 0, 10'(c), 32'(c), 4'hF);
            else if (c < 36) drive(1, 1, 10'(c-16), 32'h0, 4'h0);
            else             drive(0, 0, 10'd0, 32'h0, 4'h0);
            checks++; if (gnt_a !== (c < 36)) begin errors++; $display("FAIL sl_gnt c=%0d: got %h want %h", c, gnt_a, c < 36); end
            if (c > 0) begin
                want = (c <= 16) ? 32'h0 : (c - 17 < 16) ? 32'(c-17) : 32'hC0DE0000 | 32'(c-17);
                checks++; if (rv_a !== 1'b1) begin errors++; $display("FAIL sl_rvalid c=%0d: got %h want 1", c, rv_a); end
                checks++; if (rdata_a !== want) begin errors++; $display("FAIL sl_rdata c=%0d: got %h want %h", c, rdata_a, want); end
            end
        end
        drive(0, 0, 10'd0, 32'h0, 4'h0);
        checks++; if (rv_a !== 1'b0) begin errors++; $display("FAIL sl_idle_rvalid: got %h want 0", rv_a); end
        checks++; if (rdata_a !== 32'hC0DE0013) begin errors++; $display("FAIL sl_hold: got %h want c0de0013", rdata_a); end
    endtask

    task automatic test_byte_write();
        drive(1, 0, 10'd5, 32'hAABBCCDD, 4'hF);
        drive(1, 0, 10'd5, 32'h11223344, 4'h5);
        checks++; if (ena_a !== 4'b0010) begin errors++; $display("FAIL bw_ena: got %h want 2", ena_a); end
        checks++; if (wea_a !== 16'h0050) begin errors++; $display("FAIL bw_wea: got %h want 0050", wea_a); end
        checks++; if (addra_a !== 32'h01010101) begin errors++; $display("FAIL bw_addra: got %h want 01010101", addra_a); end
        checks++; if (dina_a !== {4{32'h11223344}}) begin errors++; $display("FAIL bw_dina: got %h want 4x11223344", dina_a); end
        drive(1, 1, 10'd5, 32'h0, 4'hF);
        checks++; if (wea_a !== 16'h0) begin errors++; $display("FAIL bw_load_wea: got %h want 0", wea_a); end
        drive(0, 0, 10'd0, 32'h0, 4'h0);
        checks++; if (rv_a !== 1'b1) begin errors++; $display("FAIL bw_rvalid: got %h want 1", rv_a); end
        checks++; if (rdata_a !== 32'hAA22CC44) begin errors++; $display("FAIL bw_rdata: got %h want aa22cc44", rdata_a); end
    endtask

    task automatic test_zero_be();
        drive(1, 0, 10'd2, 32'h12345678, 4'hF);
        drive(1, 0, 10'd2, 32'hFFFFFFFF, 4'h0);
        checks++; if (ena_a !== 4'b0100) begin errors++; $display("FAIL zb_ena: got %h want 4", ena_a); end
        checks++; if (wea_a !== 16'h0) begin errors++; $display("FAIL zb_wea: got %h want 0", wea_a); end
        drive(1, 1, 10'd2, 32'h0, 4'h0);
        checks++; if (rv_a !== 1'b1) begin errors++; $display("FAIL zb_resp: got %h want 1", rv_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("FAIL zb_resp_data: got %h want 0", rdata_a); end
        drive(0, 0, 10'd0, 32'h0, 4'h0);
        checks++; if (rdata_a !== 32'h12345678) begin errors++; $display("FAIL zb_rdata: got %h want 12345678", rdata_a); end
    endtask

    task automatic test_banking();
        drive(1, 0, 10'h007, 32'hCAFE0007, 4'hF);
        checks++; if (ena_a !== 4'b1000) begin errors++; $display("FAIL bk_il_ena: got %h want 8", ena_a); end
        checks++; if (addra_a !== 32'h01010101) begin errors++; $display("FAIL bk_il_addra: got %h want 01010101", addra_a); end
        checks++; if (wea_a !== 16'hF000) begin errors++; $display("FAIL bk_il_wea: got %h want f000", wea_a); end
        @(negedge clk);
        rst_a = 1; rst_b = 0; req = 0;
        #1;
        drive(1, 0, 10'h300, 32'h5A5A5A5A, 4'hF);
        checks++; if (ena_b !== 4'b1000) begin errors++; $display("FAIL bk_hi_ena: got %h want 8", ena_b); end
        checks++; if (wea_b !== 16'hF000) begin errors++; $display("FAIL bk_hi_wea: got %h want f000", wea_b); end
        checks++; if (addra_b !== 32'h0) begin errors++; $display("FAIL bk_hi_addra: got %h want 0", addra_b); end
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 10'd0, 32'h0, 4'h0);
            checks++; if (rv_b !== (i == 3)) begin errors++; $display("FAIL bk_store_resp i=%0d: got %h want %h", i, rv_b, i == 3); end
        end
    endtask

    task automatic test_latency();
        logic [31:0] exp_l [4] = '{32'h5A5A5A5A, 32'h0, 32'hB0000102, 32'hB0000102};
        for (int c = 0; c < 7; c++) begin
            if (c == 0)      drive(1, 1, 10'h300, 32'h0, 4'h0);
            else if (c == 1) drive(1, 0, 10'h101, 32'h77, 4'hF);
            else if (c == 2) drive(1, 1, 10'h102, 32'h0, 4'h0);
            else             drive(0, 0, 10'd0, 32'h0, 4'h0);
            checks++; if (rv_b !== (c >= 3 && c <= 5)) begin errors++; $display("FAIL lat_rvalid c=%0d: got %h want %h", c, rv_b, c >= 3 && c <= 5); end
            if (c >= 3) begin
                checks++; if (rdata_b !== exp_l[c-3]) begin errors++; $display("FAIL lat_rdata c=%0d: got %h want %h", c, rdata_b, exp_l[c-3]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        rst_b = 1; rst_c = 0; req = 0;
        #1;
        drive(1, 1, 10'd1, 32'h0, 4'h0);
        drive(1, 1, 10'd2, 32'h0, 4'h0);
        drive(1, 1, 10'd3, 32'h0, 4'h0);
        checks++; if (ena_c !== 4'b1000) begin errors++; $display("FAIL mf_ena: got %h want 8", ena_c); end
        @(negedge clk);
        rst_c = 1; req = 1; wen = 0; add = 10'd4; be = 4'hF;
        #1;
        checks++; if (gnt_c !== 1'b0) begin errors++; $display("FAIL mf_gnt: got %h want 0", gnt_c); end
        checks++; if (ena_c !== 4'h0) begin errors++; $display("FAIL mf_ena_rst: got %h want 0", ena_c); end
        checks++; if (wea_c !== 16'h0) begin errors++; $display("FAIL mf_wea_rst: got %h want 0", wea_c); end
        checks++; if (rv_c !== 1'b0) begin errors++; $display("FAIL mf_rvalid_rst: got %h want 0", rv_c); end
        checks++; if (rdata_c !== 32'h0) begin errors++; $display("FAIL mf_rdata_rst: got %h want 0", rdata_c); end
        @(negedge clk);
        rst_c = 0; req = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rv_c !== 1'b0) begin errors++; $display("FAIL mf_rvalid i=%0d: got %h want 0", i, rv_c); end
            checks++; if (rdata_c !== 32'h0) begin errors++; $display("FAIL mf_rdata i=%0d: got %h want 0", i, rdata_c); end
            drive(0, 0, 10'd0, 32'h0, 4'h0);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_write();
        test_zero_be();
        test_banking();
        test_latency();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_wrap_banked.md
BRAM_WRAP_BANKED -- requirements
Module: bram_wrap_banked

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning word address width of the request port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; a multiple of 8.
REQ-003 SHALL have parameter N_BANKS, default 4, meaning number of BRAM banks; power of 2, 1..16.
REQ-004 SHALL have parameter INTERLEAVE, default 1, meaning bank select: 1 = low address bits, 0 = high address bits.
REQ-005 SHALL have parameter RD_LATENCY, default 1, meaning BRAM read latency in cycles, 1..4.
REQ-006 SHALL use derived widths BE_WIDTH = DATA_WIDTH/8, BW = log2(N_BANKS) (0 when N_BANKS = 1), BA = ADDR_WIDTH-BW.
REQ-007 SHALL use one clock and a synchronous, active-high reset.
REQ-008 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-010 SHALL have port data_req_i, input, 1, request valid.
REQ-011 SHALL have port data_add_i, input, ADDR_WIDTH, word address; incremented by 1 per word, no byte offset.
REQ-012 SHALL have port data_wen_i, input, 1, request type: 0 = store, 1 = load.
REQ-013 SHALL have port data_wdata_i, input, DATA_WIDTH, store data.
REQ-014 SHALL have port data_be_i, input, BE_WIDTH, byte enable for stores.
REQ-015 SHALL have port data_gnt_o, output, 1, request granted this cycle.
REQ-016 SHALL have port data_r_valid_o, output, 1, response valid, for loads and stores.
REQ-017 SHALL have port data_r_rdata_o, output, DATA_WIDTH, load response data.
REQ-018 SHALL have port ADDRA_o, output, N_BANKS*BA, per-bank address; bank k in slice k.
REQ-019 SHALL have port DINA_o, output, N_BANKS*DATA_WIDTH, per-bank write data.
REQ-020 SHALL have port DOUTA_i, input, N_BANKS*DATA_WIDTH, per-bank read data.
REQ-021 SHALL have port ENA_o, output, N_BANKS, per-bank enable.
REQ-022 SHALL have port WEA_o, output, N_BANKS*BE_WIDTH, per-bank byte write enable.

Function
REQ-023 SHALL drive data_gnt_o = data_req_i & ~reset combinationally; one request per cycle, no stalls.
REQ-024 SHALL select bank = data_add_i[BW-1:0] and bank address = data_add_i[ADDR_WIDTH-1:BW] when INTERLEAVE = 1; bank = data_add_i[ADDR_WIDTH-1:BA] and bank address = data_add_i[BA-1:0] when INTERLEAVE = 0.
REQ-025 SHALL, on a granted request, assert only the selected bank's ENA_o in the same cycle; all other banks get ENA = 0 and WEA = 0.
REQ-026 SHALL drive the selected bank's WEA slice = data_be_i for a store and all-zero for a load.
REQ-027 SHALL replicate data_wdata_i onto every DINA_o slice and the bank address onto every ADDRA_o slice.
REQ-028 SHALL, for a store with data_be_i = 0, assert ENA with WEA = 0, leave memory unchanged, and still return a response.
REQ-029 SHALL carry {valid, is_load, bank} for each grant in a RD_LATENCY-deep shift pipeline; one response per grant, in order.
REQ-030 SHALL assert data_r_valid_o exactly RD_LATENCY cycles after the grant cycle, for one cycle per grant.
REQ-031 SHALL, on a load response, set data_r_rdata_o = DOUTA_i slice of the tagged bank in the valid cycle.
REQ-032 SHALL, on a store response, set data_r_rdata_o = 0.
REQ-033 SHALL hold data_r_rdata_o at its last value while data_r_valid_o = 0.
REQ-034 SHALL sustain back-to-back grants at full rate; mixed loads and stores to any banks keep order, with no bubbles.
REQ-035 SHALL, for a load to the address written in the previous cycle, return the new data (BRAM write-first); this bank behaviour is required of the connected BRAM.

Reset
REQ-036 SHALL, while reset = 1, drive data_gnt_o, ENA_o, WEA_o, data_r_valid_o = 0, data_r_rdata_o = 0, and clear the whole pipeline.
REQ-037 SHALL drop responses still in flight when reset is asserted mid-operation; none appear after reset is released.
REQ-038 SHALL accept a request in the first cycle after reset deasserts.

Verification
REQ-039 Defaults: store 0..15 to addresses 0..15 with be=0xF, then load addresses 0..19 back to back -> 20 valid responses, one cycle after each grant; data 0..15 then the BRAM content at 16..19.
REQ-040 Byte write: store 0xAABBCCDD to address 5 with be=0xF, then store 0x11223344 with be=0x5, then load -> 0xAA22CC44.
REQ-041 Banking: N_BANKS=4, INTERLEAVE=0, ADDR_WIDTH=10; store address 0x300 -> only ENA_o[3]; ADDRA slice = 0x00. With INTERLEAVE=1, address 0x007 -> ENA_o[3]; ADDRA = 0x01.
REQ-042 Latency: RD_LATENCY=3; alternate load, store, load every cycle -> r_valid at grant+3 each; the store response carries rdata = 0; load data matches the bank.
REQ-043 Reset mid-flight: RD_LATENCY=4; issue 3 loads, assert reset on the next cycle for 1 cycle -> no data_r_valid_o pulses afterwards; all outputs are 0 during reset.
REQ-044 Zero be: store with be=0 to address 2, which holds 0x12345678 -> a response is returned; a following load returns 0x12345678.
